// File: rtl/free_list_rrat_if.sv
// Rename/commit-side bundle between the ROB/rename front end and the free list + RRAT.
interface free_list_rrat_if #(
  parameter int unsigned P_REG_NUM = 64
) ();
  localparam int unsigned PW       = $clog2(P_REG_NUM);
  localparam int unsigned FL_DEPTH = P_REG_NUM - 32;
  localparam int unsigned CW       = $clog2(FL_DEPTH) + 1;

  logic          commit;
  logic [4:0]    commit_rd;
  logic [PW-1:0] commit_pd;
  logic          alloc_req;
  logic [PW-1:0] alloc_pd;
  logic          alloc_valid;
  logic          flush;
  logic [PW-1:0] rrat_map [32];
  logic [CW-1:0] free_count;

  // Front end (ROB + rename) drives strobes and consumes the free list / RRAT.
  modport master (
    output commit, commit_rd, commit_pd, alloc_req, flush,
    input  alloc_pd, alloc_valid, rrat_map, free_count
  );

  // Free list + RRAT side.
  modport slave (
    input  commit, commit_rd, commit_pd, alloc_req, flush,
    output alloc_pd, alloc_valid, rrat_map, free_count
  );
endinterface

// File: rtl/free_list_rrat.sv
// Physical-register free list with speculative/retired heads, plus the retirement RAT.
module free_list_rrat #(
  parameter int unsigned P_REG_NUM = 64
) (
  input logic            clk,
  input logic            rst,
  free_list_rrat_if.slave bus
);
  localparam int unsigned PW       = $clog2(P_REG_NUM);
  localparam int unsigned FL_DEPTH = P_REG_NUM - 32;
  localparam int unsigned IW       = $clog2(FL_DEPTH);
  localparam int unsigned CW       = IW + 1;

  logic [PW-1:0] rrat_q [32];
  logic [PW-1:0] rrat_d [32];
  logic [PW-1:0] fl_q [FL_DEPTH];
  logic [PW-1:0] fl_d [FL_DEPTH];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] rhead_q, rhead_d;
  logic [CW-1:0] tail_q, tail_d;

  logic empty_c, full_c, commit_en_c, enq_ok_c, alloc_en_c;

  // Occupancy and qualified strobes; flush wins over allocate, a full list drops the enqueue.
  always_comb begin
    empty_c     = (head_q == tail_q);
    full_c      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    commit_en_c = bus.commit && (bus.commit_rd != 5'd0);
    enq_ok_c    = commit_en_c && !full_c;
    alloc_en_c  = bus.alloc_req && !empty_c && !bus.flush;
  end

  // Next state: commit frees the old mapping, allocate advances head, flush rewinds head to rhead.
  always_comb begin
    rrat_d  = rrat_q;
    fl_d    = fl_q;
    head_d  = head_q;
    rhead_d = rhead_q;
    tail_d  = tail_q;
    if (enq_ok_c) begin
      fl_d[tail_q[IW-1:0]] = rrat_q[bus.commit_rd];
      rrat_d[bus.commit_rd] = bus.commit_pd;
      tail_d  = tail_q + CW'(1);
      rhead_d = rhead_q + CW'(1);
    end
    if (alloc_en_c) begin
      head_d = head_q + CW'(1);
    end
    if (bus.flush) begin
      head_d = rhead_d;
    end
  end

  // State registers; reset leaves the list full with p32.. in order and an identity RRAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rrat_q[i] <= PW'(i);
      end
      for (int k = 0; k < int'(FL_DEPTH); k++) begin
        fl_q[k] <= PW'(32 + k);
      end
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= {1'b1, {IW{1'b0}}};
    end else begin
      rrat_q  <= rrat_d;
      fl_q    <= fl_d;
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
    end
  end

  // Outputs are direct views of registered state.
  assign bus.alloc_pd    = fl_q[head_q[IW-1:0]];
  assign bus.alloc_valid = !empty_c;
  assign bus.free_count  = tail_q - head_q;
  assign bus.rrat_map    = rrat_q;

  // A commit can only free a register that was allocated, so the list can never be full here.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(commit_en_c && full_c))
    else $error("free_list_rrat: enqueue while free list full, commit dropped");

endmodule

// File: tb/tb_free_list_rrat.sv
// Self-checking bench: queue-based model of free list / RRAT, directed cases then random traffic.
module tb_free_list_rrat;
  localparam int unsigned P_REG_NUM = 64;
  localparam int          FLD       = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  free_list_rrat_if #(.P_REG_NUM(P_REG_NUM)) bus ();
  free_list_rrat #(.P_REG_NUM(P_REG_NUM)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int rd; int pd; } infl_t;

  int    n_chk  = 0;
  int    n_pass = 0;
  bit    inited = 1'b0;
  int    arch_free [$];   // registers free at the retired point, oldest first
  int    spec;            // how many of arch_free are handed out speculatively
  int    rrat_m [32];
  infl_t infl [$];        // renamed, not yet retired instructions in program order
  int    a_rd;            // rd to associate with the next allocation

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model, advanced on each rising edge from the inputs applied that cycle.
  int  pd_a;
  bit  fire;
  always @(posedge clk) begin
    if (rst) begin
      arch_free.delete();
      for (int k = 0; k < FLD; k++) arch_free.push_back(32 + k);
      for (int i = 0; i < 32; i++) rrat_m[i] = i;
      spec = 0;
      infl.delete();
      inited = 1'b1;
    end else if (inited) begin
      fire = bus.alloc_req && (spec < FLD) && !bus.flush;
      pd_a = (spec < FLD) ? arch_free[spec] : -1;
      if (bus.commit && bus.commit_rd != 5'd0) begin
        void'(arch_free.pop_front());
        arch_free.push_back(rrat_m[bus.commit_rd]);
        rrat_m[bus.commit_rd] = int'(bus.commit_pd);
        spec--;
        if (infl.size() > 0) void'(infl.pop_front());
      end
      if (fire) begin
        spec++;
        infl.push_back('{rd: a_rd, pd: pd_a});
      end
      if (bus.flush) begin
        spec = 0;
        infl.delete();
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, plus the pointer invariant.
  int bi;
  always @(negedge clk) begin
    if (inited) begin
      chk("alloc_valid", int'(bus.alloc_valid), int'(spec < FLD));
      chk("free_count", int'(bus.free_count), FLD - spec);
      if (spec < FLD) chk("alloc_pd", int'(bus.alloc_pd), arch_free[spec]);
      bi = 0;
      for (int i = 31; i >= 0; i--) if (int'(bus.rrat_map[i]) != rrat_m[i]) bi = i;
      chk($sformatf("rrat_map[%0d]", bi), int'(bus.rrat_map[bi]), rrat_m[bi]);
      chk("tail_minus_rhead", int'(6'(dut.tail_q - dut.rhead_q)), FLD);
    end
  end

  task automatic step(input bit c, input int rd, input int pd, input bit a, input bit f, input int ard);
    bus.commit    = c;
    bus.commit_rd = 5'(rd);
    bus.commit_pd = 6'(pd);
    bus.alloc_req = a;
    bus.flush     = f;
    a_rd          = ard;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
  endtask

  int t_before, r_before, fc_before;
  bit c, a, f;
  int crd, cpd;

  initial begin
    bus.commit = 0; bus.commit_rd = '0; bus.commit_pd = '0;
    bus.alloc_req = 0; bus.flush = 0; a_rd = 1;

    // Reset values, then drain the whole list.
    do_reset();
    chk("rst_alloc_pd", int'(bus.alloc_pd), 32);
    chk("rst_free_count", int'(bus.free_count), 32);
    chk("rst_rrat5", int'(bus.rrat_map[5]), 5);
    chk("rst_alloc_valid", int'(bus.alloc_valid), 1);
    for (int i = 0; i < 32; i++) begin
      chk("drain_alloc_pd", int'(bus.alloc_pd), 32 + i);
      step(0, 0, 0, 1, 0, (i % 31) + 1);
    end
    chk("empty_valid", int'(bus.alloc_valid), 0);
    step(0, 0, 0, 1, 0, 1);
    chk("alloc_on_empty_head", int'(dut.head_q), 32);
    chk("alloc_on_empty_count", int'(bus.free_count), 0);

    // Commit into an empty list: visible one cycle later as the old mapping of x1.
    chk("commit_cycle_valid", int'(bus.alloc_valid), 0);
    step(1, 1, 32, 0, 0, 1);
    chk("refill_valid", int'(bus.alloc_valid), 1);
    chk("refill_pd", int'(bus.alloc_pd), 1);

    // x0 commit does nothing.
    t_before = int'(dut.tail_q); r_before = int'(dut.rhead_q); fc_before = int'(bus.free_count);
    step(1, 0, 40, 0, 0, 1);
    chk("x0_rrat0", int'(bus.rrat_map[0]), 0);
    chk("x0_tail", int'(dut.tail_q), t_before);
    chk("x0_rhead", int'(dut.rhead_q), r_before);
    chk("x0_free_count", int'(bus.free_count), fc_before);

    // Alloc p32 for x5, commit it, then walk to the freed p5.
    do_reset();
    step(0, 0, 0, 1, 0, 5);
    step(1, 5, 32, 0, 0, 1);
    chk("c5_rrat5", int'(bus.rrat_map[5]), 32);
    chk("c5_free_count", int'(bus.free_count), 32);
    for (int i = 0; i < 31; i++) begin
      chk("c5_walk_pd", int'(bus.alloc_pd), 33 + i);
      step(0, 0, 0, 1, 0, 7);
    end
    chk("c5_freed_p5", int'(bus.alloc_pd), 5);

    // Allocate three, retire one, flush.
    do_reset();
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 2);
    step(0, 0, 0, 1, 0, 3);
    step(1, 1, 32, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("fl_head", int'(dut.head_q), 1);
    chk("fl_rhead", int'(dut.rhead_q), 1);
    chk("fl_alloc_pd", int'(bus.alloc_pd), 33);
    chk("fl_free_count", int'(bus.free_count), 32);
    chk("fl_rrat1", int'(bus.rrat_map[1]), 32);

    // Commit, allocate and flush together.
    do_reset();
    step(0, 0, 0, 1, 0, 3);
    step(0, 0, 0, 1, 0, 4);
    step(1, 3, 32, 1, 1, 6);
    chk("cf_rrat3", int'(bus.rrat_map[3]), 32);
    chk("cf_head", int'(dut.head_q), 1);
    chk("cf_alloc_pd", int'(bus.alloc_pd), 33);
    chk("cf_free_count", int'(bus.free_count), 32);

    // Random traffic with in-order retirement of renamed instructions.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        rst = 1'b1;
        step($urandom_range(0, 1), $urandom_range(1, 31), $urandom_range(0, 63),
             $urandom_range(0, 1), $urandom_range(0, 1), 1);
        rst = 1'b0;
      end
      c = 0; crd = 0; cpd = 0;
      if (infl.size() > 0 && ($urandom % 3) == 0) begin
        c = 1; crd = infl[0].rd; cpd = infl[0].pd;
      end else if (($urandom % 20) == 0) begin
        c = 1; crd = 0; cpd = $urandom_range(0, 63);
      end
      a = (($urandom % 5) != 0);
      f = (($urandom % 70) == 0);
      step(c, crd, cpd, a, f, $urandom_range(1, 31));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
